trak_emu: RTL

Trackball emulator driving the game core's `trakball_i` bus from host pointer deltas, plus optional digital directions. It sits beside the core in the cabinet top level, on the opposite end of the trackball interface from the game's sampler. Per-axis signed deltas are accumulated and paid out as paced single-step 4-bit quadrature-count increments with direction bits, matching what a physical trackball presents to the core.

---
 rtl/trak_emu.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/trak_emu.sv
// trak_emu: trackball emulator turning host pointer deltas into paced 4-bit quadrature counts.
// Define TRAK_JOY_EN to build the digital-direction injection path (joy_i, JOY_DIV).
module trak_emu #(
  parameter int STEP_DIV = 12000,
  parameter int JOY_DIV  = 4
) (
  input  logic       clk_12mhz,
  input  logic       reset_n,
  input  logic       delta_valid_i,
  input  logic [7:0] dx_i,
  input  logic [7:0] dy_i,
  input  logic       flip_i,
  input  logic [3:0] joy_i,
  output logic [7:0] trakball_o,
  output logic [1:0] dir_o,
  output logic       busy_o
);
  localparam int TW = $clog2(STEP_DIV);

  logic [TW-1:0]      tick_cnt;
  logic               tick;
  logic signed [9:0]  hacc, vacc, hacc_nxt, vacc_nxt;
  logic [3:0]         hcnt, vcnt;
  logic               hdir, vdir;
  logic signed [11:0] dx_ext, dy_ext, hdelta, vdelta, hjoy, vjoy, hstep, vstep;

  function automatic logic signed [9:0] sat10(input logic signed [11:0] v);
    if (v > 12'sd511)
      sat10 = 10'sd511;
    else if (v < -12'sd512)
      sat10 = -10'sd512;
    else
      sat10 = v[9:0];
  endfunction

  function automatic logic signed [11:0] step_of(input logic t, input logic signed [9:0] acc);
    step_of = 12'sd0;
    if (t && acc > 10'sd0)
      step_of = 12'sd1;
    else if (t && acc < 10'sd0)
      step_of = -12'sd1;
  endfunction

  assign tick = (tick_cnt == TW'(STEP_DIV - 1));

  always_ff @(posedge clk_12mhz or negedge reset_n) begin
    if (!reset_n)
      tick_cnt <= '0;
    else if (tick)
      tick_cnt <= '0;
    else
      tick_cnt <= tick_cnt + TW'(1);
  end

`ifdef TRAK_JOY_EN
  localparam int JW = (JOY_DIV > 1) ? $clog2(JOY_DIV) : 1;
  logic [JW-1:0] joy_cnt;
  logic          joy_fire;

  assign joy_fire = tick && (joy_cnt == JW'(JOY_DIV - 1));

  always_ff @(posedge clk_12mhz or negedge reset_n) begin
    if (!reset_n)
      joy_cnt <= '0;
    else if (joy_fire)
      joy_cnt <= '0;
    else if (tick)
      joy_cnt <= joy_cnt + JW'(1);
  end

  // joy_i = {up, down, left, right}; right/down push positive, opposites cancel
  always_comb begin
    hjoy = 12'sd0;
    vjoy = 12'sd0;
    if (joy_fire) begin
      hjoy = {11'd0, joy_i[0]} - {11'd0, joy_i[1]};
      vjoy = {11'd0, joy_i[2]} - {11'd0, joy_i[3]};
      if (flip_i) begin
        hjoy = -hjoy;
        vjoy = -vjoy;
      end
    end
  end
`else
  localparam int unused_joy_div = JOY_DIV;
  logic unused_joy;
  assign unused_joy = ^joy_i;
  assign hjoy = 12'sd0;
  assign vjoy = 12'sd0;
`endif

  assign dx_ext = {{4{dx_i[7]}}, dx_i};
  assign dy_ext = {{4{dy_i[7]}}, dy_i};

  always_comb begin
    hdelta = 12'sd0;
    vdelta = 12'sd0;
    if (delta_valid_i) begin
      hdelta = flip_i ? -dx_ext : dx_ext;
      vdelta = flip_i ? -dy_ext : dy_ext;
    end
  end

  // Step is taken from the pre-update accumulator so a same-cycle delta is never lost.
  assign hstep    = step_of(tick, hacc);
  assign vstep    = step_of(tick, vacc);
  assign hacc_nxt = sat10({{2{hacc[9]}}, hacc} + hdelta + hjoy - hstep);
  assign vacc_nxt = sat10({{2{vacc[9]}}, vacc} + vdelta + vjoy - vstep);

  always_ff @(posedge clk_12mhz or negedge reset_n) begin
    if (!reset_n) begin
      hacc   <= '0;
      vacc   <= '0;
      hcnt   <= '0;
      vcnt   <= '0;
      hdir   <= 1'b0;
      vdir   <= 1'b0;
      busy_o <= 1'b0;
    end else begin
      hacc   <= hacc_nxt;
      vacc   <= vacc_nxt;
      busy_o <= (hacc != 10'sd0) || (vacc != 10'sd0);
      if (hstep == 12'sd1) begin
        hcnt <= hcnt + 4'd1;
        hdir <= 1'b0;
      end else if (hstep == -12'sd1) begin
        hcnt <= hcnt - 4'd1;
        hdir <= 1'b1;
      end
      if (vstep == 12'sd1) begin
        vcnt <= vcnt + 4'd1;
        vdir <= 1'b0;
      end else if (vstep == -12'sd1) begin
        vcnt <= vcnt - 4'd1;
        vdir <= 1'b1;
      end
    end
  end

  assign trakball_o = {vcnt, hcnt};
  assign dir_o      = {vdir, hdir};
endmodule
